// File: rtl/sd_wr_buffer.sv
// sd_wr_buffer
// Feeds bytes to an SPI-mode SD single-block write engine. Incoming bytes are
// packed big-endian into 16-bit words in a 2x256-word ping-pong RAM. Each full
// bank is one 512-byte sector. The drain FSM starts the engine for that sector
// and returns one word per wr_req. Sectors go to consecutive addresses starting
// at SEC_START.

module sd_wr_buffer #(
   parameter logic [31:0] SEC_START   = 32'd2048,
   parameter logic [31:0] NUM_SECTORS = 32'd0,
   parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
   input  logic        clk_ref,
   input  logic        rst,
   input  logic        sd_init_done,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        flush,
   output logic        wr_start_en,
   output logic [31:0] wr_sec_addr,
   output logic [15:0] wr_data,
   input  logic        wr_busy,
   input  logic        wr_req,
   output logic [31:0] sec_cnt,
   output logic        done,
   output logic        req_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;

   // Ping-pong RAM. The bank number is the top address bit.
   logic [15:0] r_mem [0:511];

   // Fill side
   logic        r_alive;        // low for the first cycle after reset
   logic        r_fill_bank;
   logic [7:0]  r_wptr;
   logic        r_half_vld;     // byte 0 of a pair is held
   logic [7:0]  r_half_byte;
   logic [1:0]  r_full;
   logic        r_flush_pend;
   logic        r_padding;

   // Drain side
   logic [2:0]  r_state;
   logic        r_drain_bank;
   logic [7:0]  r_rptr;
   logic        r_start_en;
   logic [31:0] r_sec_addr;
   logic [15:0] r_wr_data;
   logic [31:0] r_sec_cnt;
   logic        r_done;
   logic        r_req_err;

   logic        w_in_ready;
   logic        w_in_fire;
   logic        w_flush_go;
   logic        w_flush_noop;
   logic        w_mem_we;
   logic [15:0] w_mem_wdata;
   logic        w_bank_done;
   logic        w_clr_full;

   // A pending flush also holds off new bytes. The pad-or-skip decision then
   // sees a stable fill pointer. A byte that arrives with the flush pulse
   // itself is still accepted and stored first.
   assign w_in_ready   = r_alive & ~r_full[r_fill_bank] & ~r_padding
                       & ~r_flush_pend & ~r_done;
   assign w_in_fire    = in_valid & w_in_ready;
   assign w_flush_go   = r_flush_pend & ~r_padding & ~r_full[r_fill_bank] & ~r_done;
   assign w_flush_noop = (r_wptr == 8'd0) & ~r_half_vld;
   assign w_bank_done  = w_mem_we & (r_wptr == 8'hFF);
   assign w_clr_full   = (r_state == S_NEXT);

   // Select the RAM write word: a padding word, or a completed byte pair.
   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_wdata = 16'h0000;
      if (r_padding) begin
         w_mem_we    = 1'b1;
         w_mem_wdata = r_half_vld ? {r_half_byte, PAD_BYTE} : {PAD_BYTE, PAD_BYTE};
      end else if (w_in_fire && r_half_vld) begin
         w_mem_we    = 1'b1;
         w_mem_wdata = {r_half_byte, in_data};
      end
   end

   // RAM write port, owned by the fill side.
   // NOTE: the RAM has no reset. A bank is only read after it has been completely written, so its reset contents do not matter.
   always_ff @(posedge clk_ref) begin
      if (w_mem_we) begin
         r_mem[{r_fill_bank, r_wptr}] <= w_mem_wdata;
      end
   end

   // Fill side: byte pairing, word pointer, flush/padding, and bank-full flags.
   // NOTE: sequential state uses non-blocking assignments only, so every block sees the values from before the edge.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_alive      <= 1'b0;
         r_fill_bank  <= 1'b0;
         r_wptr       <= 8'd0;
         r_half_vld   <= 1'b0;
         r_half_byte  <= 8'h00;
         r_full       <= 2'b00;
         r_flush_pend <= 1'b0;
         r_padding    <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (w_in_fire && !r_half_vld) begin
            r_half_vld  <= 1'b1;
            r_half_byte <= in_data;
         end
         if (w_mem_we) begin
            r_half_vld <= 1'b0;
            r_wptr     <= r_wptr + 8'd1;
            if (w_bank_done) begin
               r_full[r_fill_bank] <= 1'b1;
               r_fill_bank         <= ~r_fill_bank;
               r_padding           <= 1'b0;
               r_flush_pend        <= 1'b0;
            end
         end
         if (w_flush_go) begin
            if (w_flush_noop) begin
               r_flush_pend <= 1'b0;
            end else begin
               r_padding <= 1'b1;
            end
         end
         // The drain side only ever clears the bank it is reading. That bank
         // is full, so it is never the bank being filled this cycle.
         if (w_clr_full) begin
            r_full[r_drain_bank] <= 1'b0;
         end
         // A new flush pulse wins over any clear in the same cycle.
         if (flush) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   // Drain FSM: start the engine, answer wr_req with words, then advance the sector.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_drain_bank <= 1'b0;
         r_rptr       <= 8'd0;
         r_start_en   <= 1'b0;
         r_sec_addr   <= SEC_START;
         r_wr_data    <= 16'h0000;
         r_sec_cnt    <= 32'd0;
         r_done       <= 1'b0;
         r_req_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!r_done && r_full[r_drain_bank] && sd_init_done && !wr_busy) begin
                  r_start_en <= 1'b1;
                  r_state    <= S_START;
               end
            end
            S_START: begin
               if (wr_busy) begin
                  r_start_en <= 1'b0;
                  r_state    <= S_XFER;
               end
            end
            S_XFER: begin
               if (wr_req) begin
                  r_wr_data <= r_mem[{r_drain_bank, r_rptr}];
                  r_rptr    <= r_rptr + 8'd1;
                  if (r_rptr == 8'hFF) begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!wr_busy) begin
                  r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               r_drain_bank <= ~r_drain_bank;
               r_sec_cnt    <= r_sec_cnt + 32'd1;
               r_sec_addr   <= r_sec_addr + 32'd1;
               if ((NUM_SECTORS != 32'd0) && ((r_sec_cnt + 32'd1) == NUM_SECTORS)) begin
                  r_done <= 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         // A word request outside XFER (which includes any request after
         // word 255) is ignored. It leaves wr_data alone and is flagged.
         if (wr_req && (r_state != S_XFER)) begin
            r_req_err <= 1'b1;
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign wr_start_en = r_start_en;
   assign wr_sec_addr = r_sec_addr;
   assign wr_data     = r_wr_data;
   assign sec_cnt     = r_sec_cnt;
   assign done        = r_done;
   assign req_err     = r_req_err;

endmodule
